uc_multicycle_hs: RTL and testbench
===================================

Name: uc_multicycle_hs

Overview:
Multicycle control unit for the RV64I datapath (PC, IR, regA/regB, ALUOut, MDR, bancoReg, ula64, 3 operand muxes). It succeeds the fixed-timing controller. New capabilities:
- Variable-latency instruction and data memories through req/ready handshakes.
- Illegal-opcode trapping.
- A retired-instruction counter.
- Optional memory watchdog.
The datapath is unchanged; only control sequencing grows.

Parameters:
CNT_W, 32, width of instret counter
TIMEOUT_CYC, 16, cycles a memory req may wait before trap (used only with watchdog feature)
HALT_ON_TRAP, 1, 1: TRAP state is terminal; 0: TRAP for 1 cycle then FETCH (skip instruction via PC+4)

Ports:
clock  in  1  system clock
reset  in  1  async active-high reset
instr  in  32  IR contents (Instr31_0)
alu_eq  in  1  ula64 Igual flag
imem_ready  in  1  instruction word valid this cycle
dmem_ready  in  1  data read valid / write accepted this cycle
imem_req  out  1  instruction fetch request
dmem_req  out  1  data access request
dmem_we  out  1  data write (qualified by dmem_req)
load_ir  out  1  IR load
pc_write  out  1  PC load from ALU result
load_a  out  1  regA load
load_b  out  1  regB load
load_aluout  out  1  ALUOut load
load_mdr  out  1  MDR load
reg_write  out  1  register bank write
alu_src_a  out  3  mux1 select
alu_src_b  out  3  mux2 select
alu_fct  out  3  ula64 function
mem_to_reg  out  3  mux3 select
instr_type  out  3  sign-extend format
trap  out  1  high while in TRAP
trap_cause  out  2  0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout
instret  out  CNT_W  retired-instruction count
state_dbg  out  5  current state encoding

Behaviour:
- Single clock `clock`. Asynchronous active-high `reset`. All outputs are registered-state decodes (Moore).
- On reset:
  - state=RESET; every strobe/req=0; selects=0.
  - instret=0; trap_cause=0.
  - RESET -> FETCH on the next edge.
- FETCH:
  - imem_req=1 until imem_ready.
  - load_ir=1 only in the cycle imem_ready=1, which is also the transition to DECODE.
  - Otherwise stay in FETCH.
- DECODE: load_a=load_b=1. Dispatch on instr[6:0]:
  - 0110011 -> EXE_R
  - 0010011 -> EXE_I
  - 0000011 or 0100011 -> ADDR
  - 1100011 -> BR_CMP
  - 0110111 -> LUI
  - 1110011 -> HALT
  - any other -> TRAP with cause 1
- EXE_R: src_a=regA, src_b=regB. fct=ADD, or SUB if instr[30]. load_aluout -> WB_ALU.
- EXE_I: src_a=regA, src_b=EXT, type=I, fct=ADD, load_aluout -> WB_ALU.
- ADDR: src_a=regA, src_b=EXT, type=I for load / S for store, fct=ADD, load_aluout. Loads -> MEM_RD; stores -> MEM_WR.
- MEM_RD: dmem_req=1. load_mdr=1 in the dmem_ready cycle -> WB_MEM.
- MEM_WR: dmem_req=dmem_we=1. On dmem_ready -> PC_INC.
- WB_ALU: reg_write=1, mem_to_reg=ALU -> PC_INC.
- WB_MEM: reg_write=1, mem_to_reg=MDR -> PC_INC.
- LUI: src_a=ZERO, src_b=EXT, type=U, fct=ADD, load_aluout -> WB_ALU.
- BR_CMP:
  - fct=CMP, src_a=regA, src_b=regB.
  - taken = alu_eq XOR instr[12] (BEQ/BNE); any other funct3 -> TRAP cause 1.
  - taken -> BR_TAKE; else PC_INC.
- BR_TAKE: src_a=PC, src_b=EXT, type=SB, fct=ADD, pc_write=1 -> FETCH.
- PC_INC: src_a=PC, src_b=FOUR, fct=ADD, pc_write=1 -> FETCH.
- instret increments by 1 on every pc_write in PC_INC/BR_TAKE. It wraps modulo 2^CNT_W.
- HALT: terminal. No strobes. instret frozen.
- TRAP:
  - trap=1, trap_cause held.
  - HALT_ON_TRAP=1: stay in TRAP.
  - HALT_ON_TRAP=0: behave as PC_INC for one cycle (pc_write, no instret increment), clear trap_cause, -> FETCH.
- Handshakes:
  - req stays asserted until ready is sampled high.
  - ready while req=0 is ignored.
  - ready asserted in the same cycle req first rises is accepted (zero-wait).
- Reset mid-handshake drops req asynchronously. No strobe may glitch high during reset.

Optional Feature:
UC_MEM_WATCHDOG_EN.
- Defined:
  - A counter clears on entry to FETCH/MEM_RD/MEM_WR and counts cycles with req=1 & ready=0.
  - Reaching TIMEOUT_CYC -> TRAP, cause 2 (imem) or 3 (dmem). req drops the same edge.
- Undefined:
  - No counter; waits are unbounded.
  - Causes 2/3 never occur; TIMEOUT_CYC is unused.

Decomposition:
- Package uc_pkg holds:
  - state enum (5-bit).
  - ALU function codes: LOAD=000, ADD=001, SUB=010, AND=011, INC=100, NOT=101, XOR=110, CMP=111.
  - src_a codes: PC=0, REGA=1, ZERO=2, ONE=3.
  - src_b codes: REGB=0, FOUR=1, EXT=2, ZERO=3, ONE=4.
  - mem_to_reg codes: MDR=0, ALU=1.
  - instr_type codes: I=0, S=1, SB=2, U=3.
  - opcode constants and trap cause codes.
- One sub-module, uc_mem_watchdog: counter plus timeout compare, instantiated under the macro.

Test Plan:
- ADD x3,x1,x2 with imem_ready 3 cycles late -> FETCH holds imem_req 4 cycles. Sequence FETCH, DECODE, EXE_R (fct=001), WB_ALU (reg_write), PC_INC (pc_write). instret 0 -> 1.
- LD with dmem_ready in the same cycle as dmem_req -> MEM_RD lasts 1 cycle, load_mdr=1, WB_MEM with mem_to_reg=0.
- SD, dmem_ready after 2 cycles -> dmem_we=1 throughout MEM_WR. reg_write never asserted.
- BEQ with alu_eq=1 -> BR_TAKE, src_b=2, type=SB. BNE with alu_eq=1 -> PC_INC. Each retires 1.
- Opcode 0x7F -> TRAP, trap_cause=1. HALT_ON_TRAP=1 keeps all strobes 0 forever. Reset mid-trap -> RESET then FETCH, cause=0.
- With UC_MEM_WATCHDOG_EN and TIMEOUT_CYC=4, imem_ready held 0 -> TRAP cause 2 after 4 req cycles. Without the macro -> FETCH indefinitely.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared types, select codes and the per-state control decode for the
// handshaked RV64I multicycle controller.
package uc_pkg;

    typedef enum logic [4:0] {
        ST_RESET   = 5'd0,
        ST_FETCH   = 5'd1,
        ST_DECODE  = 5'd2,
        ST_EXE_R   = 5'd3,
        ST_EXE_I   = 5'd4,
        ST_ADDR    = 5'd5,
        ST_MEM_RD  = 5'd6,
        ST_MEM_WR  = 5'd7,
        ST_WB_ALU  = 5'd8,
        ST_WB_MEM  = 5'd9,
        ST_LUI     = 5'd10,
        ST_BR_CMP  = 5'd11,
        ST_BR_TAKE = 5'd12,
        ST_PC_INC  = 5'd13,
        ST_HALT    = 5'd14,
        ST_TRAP    = 5'd15
    } state_t;

    localparam logic [2:0] FCT_LOAD = 3'b000;
    localparam logic [2:0] FCT_ADD  = 3'b001;
    localparam logic [2:0] FCT_SUB  = 3'b010;
    localparam logic [2:0] FCT_AND  = 3'b011;
    localparam logic [2:0] FCT_INC  = 3'b100;
    localparam logic [2:0] FCT_NOT  = 3'b101;
    localparam logic [2:0] FCT_XOR  = 3'b110;
    localparam logic [2:0] FCT_CMP  = 3'b111;

    localparam logic [2:0] SRCA_PC   = 3'd0;
    localparam logic [2:0] SRCA_REGA = 3'd1;
    localparam logic [2:0] SRCA_ZERO = 3'd2;
    localparam logic [2:0] SRCA_ONE  = 3'd3;

    localparam logic [2:0] SRCB_REGB = 3'd0;
    localparam logic [2:0] SRCB_FOUR = 3'd1;
    localparam logic [2:0] SRCB_EXT  = 3'd2;
    localparam logic [2:0] SRCB_ZERO = 3'd3;
    localparam logic [2:0] SRCB_ONE  = 3'd4;

    localparam logic [2:0] M2R_MDR = 3'd0;
    localparam logic [2:0] M2R_ALU = 3'd1;

    localparam logic [2:0] TYPE_I  = 3'd0;
    localparam logic [2:0] TYPE_S  = 3'd1;
    localparam logic [2:0] TYPE_SB = 3'd2;
    localparam logic [2:0] TYPE_U  = 3'd3;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       pc_write;
        logic       load_a;
        logic       load_b;
        logic       load_aluout;
        logic       reg_write;
        logic       trap;
        logic [2:0] src_a;
        logic [2:0] src_b;
        logic [2:0] fct;
        logic [2:0] mem_to_reg;
        logic [2:0] itype;
    } ctrl_t;

    // Moore decode of a state; evaluated on the next state so outputs come straight from flops.
    function automatic ctrl_t ctrl_for(state_t st, logic [31:0] ir, logic halt_on_trap);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH:  c.imem_req = 1'b1;
            ST_DECODE: begin
                c.load_a = 1'b1;
                c.load_b = 1'b1;
            end
            ST_EXE_R: begin
                c.src_a       = SRCA_REGA;
                c.src_b       = SRCB_REGB;
                c.fct         = ir[30] ? FCT_SUB : FCT_ADD;
                c.load_aluout = 1'b1;
            end
            ST_EXE_I: begin
                c.src_a       = SRCA_REGA;
                c.src_b       = SRCB_EXT;
                c.itype       = TYPE_I;
                c.fct         = FCT_ADD;
                c.load_aluout = 1'b1;
            end
            ST_ADDR: begin
                c.src_a       = SRCA_REGA;
                c.src_b       = SRCB_EXT;
                c.itype       = (ir[6:0] == OP_STORE) ? TYPE_S : TYPE_I;
                c.fct         = FCT_ADD;
                c.load_aluout = 1'b1;
            end
            ST_MEM_RD: c.dmem_req = 1'b1;
            ST_MEM_WR: begin
                c.dmem_req = 1'b1;
                c.dmem_we  = 1'b1;
            end
            ST_WB_ALU: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = M2R_ALU;
            end
            ST_WB_MEM: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = M2R_MDR;
            end
            ST_LUI: begin
                c.src_a       = SRCA_ZERO;
                c.src_b       = SRCB_EXT;
                c.itype       = TYPE_U;
                c.fct         = FCT_ADD;
                c.load_aluout = 1'b1;
            end
            ST_BR_CMP: begin
                c.src_a = SRCA_REGA;
                c.src_b = SRCB_REGB;
                c.fct   = FCT_CMP;
            end
            ST_BR_TAKE: begin
                c.src_a    = SRCA_PC;
                c.src_b    = SRCB_EXT;
                c.itype    = TYPE_SB;
                c.fct      = FCT_ADD;
                c.pc_write = 1'b1;
            end
            ST_PC_INC: begin
                c.src_a    = SRCA_PC;
                c.src_b    = SRCB_FOUR;
                c.fct      = FCT_ADD;
                c.pc_write = 1'b1;
            end
            ST_TRAP: begin
                c.trap = 1'b1;
                if (!halt_on_trap) begin
                    c.src_a    = SRCA_PC;
                    c.src_b    = SRCB_FOUR;
                    c.fct      = FCT_ADD;
                    c.pc_write = 1'b1;
                end
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/uc_mem_watchdog.sv
// Counts consecutive stalled memory-request cycles and flags a timeout on the
// cycle that would reach TIMEOUT_CYC, so the controller can trap on that edge.
module uc_mem_watchdog #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic req,
    input  logic ready,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          waiting;

    assign waiting = req & ~ready;

    // Any non-waiting cycle separates two accesses, so it also serves as the clear on entry.
    always_comb begin
        cnt_d = '0;
        if (waiting) cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign timeout = waiting && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uc_multicycle_hs.sv
// Handshaked multicycle control unit for the RV64I datapath with illegal-opcode
// trapping and a retired-instruction counter. Optional feature: UC_MEM_WATCHDOG_EN.
module uc_multicycle_hs
    import uc_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int TIMEOUT_CYC  = 16,
    parameter bit HALT_ON_TRAP = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             alu_eq,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             load_ir,
    output logic             pc_write,
    output logic             load_a,
    output logic             load_b,
    output logic             load_aluout,
    output logic             load_mdr,
    output logic             reg_write,
    output logic [2:0]       alu_src_a,
    output logic [2:0]       alu_src_b,
    output logic [2:0]       alu_fct,
    output logic [2:0]       mem_to_reg,
    output logic [2:0]       instr_type,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret,
    output logic [4:0]       state_dbg
);

    state_t           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             wd_timeout;

`ifdef UC_MEM_WATCHDOG_EN
    logic mem_req, mem_ready;

    assign mem_req   = ctrl_q.imem_req | ctrl_q.dmem_req;
    assign mem_ready = ctrl_q.imem_req ? imem_ready : dmem_ready;

    uc_mem_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .req    (mem_req),
        .ready  (mem_ready),
        .timeout(wd_timeout)
    );
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign wd_timeout         = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        instret_d = instret_q;
        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ready) begin
                    state_d = ST_DECODE;
                end else if (wd_timeout) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_IMEM_TO;
                end
            end
            ST_DECODE: begin
                case (instr[6:0])
                    OP_R:               state_d = ST_EXE_R;
                    OP_IMM:             state_d = ST_EXE_I;
                    OP_LOAD, OP_STORE:  state_d = ST_ADDR;
                    OP_BRANCH:          state_d = ST_BR_CMP;
                    OP_LUI:             state_d = ST_LUI;
                    OP_SYSTEM:          state_d = ST_HALT;
                    default: begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            ST_EXE_R, ST_EXE_I, ST_LUI: state_d = ST_WB_ALU;
            ST_ADDR: state_d = (instr[6:0] == OP_STORE) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (dmem_ready) begin
                    state_d = ST_WB_MEM;
                end else if (wd_timeout) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_DMEM_TO;
                end
            end
            ST_MEM_WR: begin
                if (dmem_ready) begin
                    state_d = ST_PC_INC;
                end else if (wd_timeout) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_DMEM_TO;
                end
            end
            ST_WB_ALU, ST_WB_MEM: state_d = ST_PC_INC;
            // Only BEQ (000) and BNE (001) exist; funct3[0] inverts the equality test.
            ST_BR_CMP: begin
                if (instr[14:13] != 2'b00) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (alu_eq ^ instr[12]) begin
                    state_d = ST_BR_TAKE;
                end else begin
                    state_d = ST_PC_INC;
                end
            end
            ST_BR_TAKE, ST_PC_INC: begin
                state_d   = ST_FETCH;
                instret_d = instret_q + CNT_W'(1);
            end
            ST_HALT: state_d = ST_HALT;
            ST_TRAP: begin
                if (!HALT_ON_TRAP) begin
                    state_d = ST_FETCH;
                    cause_d = CAUSE_NONE;
                end
            end
            default: state_d = ST_RESET;
        endcase
        ctrl_d = ctrl_for(state_d, instr, HALT_ON_TRAP);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RESET;
            ctrl_q    <= '0;
            cause_q   <= CAUSE_NONE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

    // Capture strobes fire in the ready cycle itself; gating with the registered request keeps them clean in reset.
    assign load_ir     = ctrl_q.imem_req & imem_ready;
    assign load_mdr    = ctrl_q.dmem_req & ~ctrl_q.dmem_we & dmem_ready;

    assign imem_req    = ctrl_q.imem_req;
    assign dmem_req    = ctrl_q.dmem_req;
    assign dmem_we     = ctrl_q.dmem_we;
    assign pc_write    = ctrl_q.pc_write;
    assign load_a      = ctrl_q.load_a;
    assign load_b      = ctrl_q.load_b;
    assign load_aluout = ctrl_q.load_aluout;
    assign reg_write   = ctrl_q.reg_write;
    assign alu_src_a   = ctrl_q.src_a;
    assign alu_src_b   = ctrl_q.src_b;
    assign alu_fct     = ctrl_q.fct;
    assign mem_to_reg  = ctrl_q.mem_to_reg;
    assign instr_type  = ctrl_q.itype;
    assign trap        = ctrl_q.trap;
    assign trap_cause  = cause_q;
    assign instret     = instret_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_uc_multicycle_hs.sv
// Self-checking bench for uc_multicycle_hs: random instruction mix with random
// memory latencies against a per-instruction-class cycle/strobe model.
`timescale 1ns/1ps
module tb_uc_multicycle_hs;
    import uc_pkg::*;

    localparam int CNT_W       = 4;
    localparam int TIMEOUT_CYC = 4;
    localparam int NEVER       = 1000;

    localparam int K_R   = 0;
    localparam int K_I   = 1;
    localparam int K_LUI = 2;
    localparam int K_LD  = 3;
    localparam int K_SD  = 4;
    localparam int K_BEQ = 5;
    localparam int K_BNE = 6;

    logic             clock = 1'b0;
    logic             reset;
    logic [31:0]      instr;
    logic             alu_eq;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req, dmem_req, dmem_we, load_ir, pc_write;
    logic             load_a, load_b, load_aluout, load_mdr, reg_write;
    logic [2:0]       alu_src_a, alu_src_b, alu_fct, mem_to_reg, instr_type;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] instret;
    logic [4:0]       state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_instret  = 0;
    int iwait        = 0;
    int dwait        = 0;

    always #5 clock = ~clock;

    uc_multicycle_hs #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .HALT_ON_TRAP(1'b1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .instr      (instr),
        .alu_eq     (alu_eq),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .load_ir    (load_ir),
        .pc_write   (pc_write),
        .load_a     (load_a),
        .load_b     (load_b),
        .load_aluout(load_aluout),
        .load_mdr   (load_mdr),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_fct    (alu_fct),
        .mem_to_reg (mem_to_reg),
        .instr_type (instr_type),
        .trap       (trap),
        .trap_cause (trap_cause),
        .instret    (instret),
        .state_dbg  (state_dbg)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [10:0] strobes();
        return {imem_req, dmem_req, dmem_we, load_ir, pc_write, load_a, load_b,
                load_aluout, load_mdr, reg_write, trap};
    endfunction

    // Memories answer after the requested number of wait cycles; ready toggles randomly while unrequested.
    task automatic applyStimulus(input int ilat, input int dlat);
        if (imem_req) begin
            imem_ready = (iwait >= ilat);
            iwait++;
        end else begin
            imem_ready = 1'($urandom_range(0, 1));
        end
        if (dmem_req) begin
            dmem_ready = (dwait >= dlat);
            dwait++;
        end else begin
            dmem_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic step(input int ilat, input int dlat);
        @(negedge clock);
        applyStimulus(ilat, dlat);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        #1;
        checkOutput("rst_strobes", 32'(strobes()), 0);
        checkOutput("rst_state", 32'(state_dbg), 32'(ST_RESET));
        checkOutput("rst_cause", 32'(trap_cause), 0);
        checkOutput("rst_instret", 32'(instret), 0);
        @(negedge clock);
        reset       = 1'b0;
        exp_instret = 0;
        iwait       = 0;
        dwait       = 0;
    endtask

    function automatic logic [31:0] make_instr(input int k);
        logic [31:0] w;
        w = $urandom;
        case (k)
            K_R:     w[6:0] = 7'b0110011;
            K_I:     w[6:0] = 7'b0010011;
            K_LUI:   w[6:0] = 7'b0110111;
            K_LD:    w[6:0] = 7'b0000011;
            K_SD:    w[6:0] = 7'b0100011;
            K_BEQ:   begin w[6:0] = 7'b1100011; w[14:12] = 3'b000; end
            default: begin w[6:0] = 7'b1100011; w[14:12] = 3'b001; end
        endcase
        return w;
    endfunction

    task automatic fetch_decode(input logic [31:0] ins, input int ilat, input int dlat);
        bit seen;
        seen  = 1'b0;
        instr = ins;
        iwait = 0;
        dwait = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            step(ilat, dlat);
            if (load_a && load_b) seen = 1'b1;
        end
        checkOutput("decode_reached", 32'(seen), 1);
    endtask

    // Runs one retiring instruction from its first FETCH cycle through its PC update.
    task automatic run_instr(input int k, input logic [31:0] ins, input logic eq, input int ilat, input int dlat);
        int cyc, ireq, irl, dreq, dwe, mdr, regw, aluld, ldab, pcw, exp_cycles;
        logic [2:0] m2r, al_fct, al_a, al_b, al_t, pc_a, pc_b, pc_t, pc_f;
        bit done, is_br, is_ld, is_sd, wr, taken;
        {cyc, ireq, irl, dreq, dwe, mdr, regw, aluld, ldab, pcw} = '0;
        {m2r, al_fct, al_a, al_b, al_t, pc_a, pc_b, pc_t, pc_f} = '0;
        done   = 1'b0;
        instr  = ins;
        alu_eq = eq;
        iwait  = 0;
        dwait  = 0;
        is_br  = (k == K_BEQ) || (k == K_BNE);
        is_ld  = (k == K_LD);
        is_sd  = (k == K_SD);
        wr     = !is_br && !is_sd;
        taken  = (k == K_BEQ) ? eq : ((k == K_BNE) ? !eq : 1'b0);
        if (is_br)      exp_cycles = ilat + 4;
        else if (is_ld) exp_cycles = ilat + dlat + 6;
        else if (is_sd) exp_cycles = ilat + dlat + 5;
        else            exp_cycles = ilat + 5;

        for (int c = 0; c < 80 && !done; c++) begin
            step(ilat, dlat);
            if (c == 0) begin
                checkOutput("fetch_first_req", 32'(imem_req), 1);
                checkOutput("instret", 32'(instret), exp_instret);
            end
            cyc++;
            if (imem_req) ireq++;
            if (load_ir) irl++;
            if (load_a && load_b) ldab++;
            if (dmem_req) dreq++;
            if (dmem_req && dmem_we) dwe++;
            if (load_mdr) mdr++;
            if (reg_write) begin regw++; m2r = mem_to_reg; end
            if (load_aluout) begin
                aluld++;
                al_fct = alu_fct; al_a = alu_src_a; al_b = alu_src_b; al_t = instr_type;
            end
            if (pc_write) begin
                pcw++;
                pc_a = alu_src_a; pc_b = alu_src_b; pc_t = instr_type; pc_f = alu_fct;
                done = 1'b1;
            end
        end

        checkOutput("retire_seen", 32'(done), 1);
        checkOutput("instr_cycles", cyc, exp_cycles);
        checkOutput("imem_req_cycles", ireq, ilat + 1);
        checkOutput("load_ir_pulses", irl, 1);
        checkOutput("decode_ab_pulses", ldab, 1);
        checkOutput("dmem_req_cycles", dreq, (is_ld || is_sd) ? dlat + 1 : 0);
        checkOutput("dmem_we_cycles", dwe, is_sd ? dlat + 1 : 0);
        checkOutput("load_mdr_pulses", mdr, is_ld ? 1 : 0);
        checkOutput("reg_write_pulses", regw, wr ? 1 : 0);
        if (wr) checkOutput("mem_to_reg", 32'(m2r), is_ld ? 0 : 1);
        checkOutput("aluout_loads", aluld, is_br ? 0 : 1);
        if (!is_br) begin
            checkOutput("alu_fct", 32'(al_fct), (k == K_R && ins[30]) ? 2 : 1);
            checkOutput("alu_src_a", 32'(al_a), (k == K_LUI) ? 2 : 1);
            checkOutput("alu_src_b", 32'(al_b), (k == K_R) ? 0 : 2);
            if (k != K_R) checkOutput("instr_type", 32'(al_t), is_sd ? 1 : ((k == K_LUI) ? 3 : 0));
        end
        checkOutput("pc_write_pulses", pcw, 1);
        checkOutput("pc_src_a", 32'(pc_a), 0);
        checkOutput("pc_src_b", 32'(pc_b), taken ? 2 : 1);
        checkOutput("pc_fct", 32'(pc_f), 1);
        if (taken) checkOutput("pc_type", 32'(pc_t), 2);
        exp_instret = (exp_instret + 1) % (1 << CNT_W);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int cnt;
        bit seen_trap;
        reset      = 1'b1;
        instr      = '0;
        alu_eq     = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        checkOutput("init_strobes", 32'(strobes()), 0);
        checkOutput("init_selects", 32'({alu_src_a, alu_src_b, alu_fct, mem_to_reg, instr_type}), 0);
        checkOutput("init_state", 32'(state_dbg), 32'(ST_RESET));
        checkOutput("init_instret", 32'(instret), 0);
        checkOutput("init_cause", 32'(trap_cause), 0);
        repeat (2) @(negedge clock);
        imem_ready = 1'b1;
        #1;
        checkOutput("rst_ready_ignored", 32'(load_ir), 0);
        reset = 1'b0;

        // Directed: late imem, zero-wait load, slow store, BEQ taken, BNE not taken
        run_instr(K_R,   32'h002081B3,            1'b0, 3, 0);
        run_instr(K_LD,  make_instr(K_LD),        1'b0, 0, 0);
        run_instr(K_SD,  make_instr(K_SD),        1'b1, 1, 2);
        run_instr(K_BEQ, make_instr(K_BEQ),       1'b1, 0, 0);
        run_instr(K_BNE, make_instr(K_BNE),       1'b1, 2, 0);
        run_instr(K_R,   32'h40208133,            1'b0, 0, 0);

        for (int n = 0; n < 30; n++) begin
            int k;
            k = int'($urandom_range(0, 6));
            run_instr(k, make_instr(k), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // HALT freezes everything
        fetch_decode(32'h00000073, 1, 0);
        for (int c = 0; c < 5; c++) begin
            step(0, 0);
            checkOutput("halt_state", 32'(state_dbg), 32'(ST_HALT));
            checkOutput("halt_strobes", 32'(strobes()), 0);
            checkOutput("halt_instret", 32'(instret), exp_instret);
        end
        reset_dut();

        // Illegal opcode traps and stays trapped; reset mid-trap recovers
        fetch_decode(32'h0000007F, 0, 0);
        for (int c = 0; c < 6; c++) begin
            step(0, 0);
            checkOutput("trap_strobes", 32'(strobes()), 1);
            checkOutput("trap_cause_illegal", 32'(trap_cause), 1);
        end
        reset_dut();
        step(0, 0);
        checkOutput("post_reset_fetch", 32'(state_dbg), 32'(ST_FETCH));

        // Branch with unsupported funct3 traps from the compare state
        alu_eq = 1'b1;
        fetch_decode(32'h0020A063, 0, 0);
        step(0, 0);
        checkOutput("brcmp_fct", 32'(alu_fct), 7);
        checkOutput("brcmp_srcs", 32'({alu_src_a, alu_src_b}), 32'({3'd1, 3'd0}));
        step(0, 0);
        checkOutput("br_funct3_trap", 32'(trap), 1);
        checkOutput("br_funct3_cause", 32'(trap_cause), 1);
        checkOutput("br_funct3_no_retire", 32'(instret), 0);
        reset_dut();

        // Reset in the middle of a fetch handshake drops the request at once
        step(NEVER, 0);
        step(NEVER, 0);
        checkOutput("hs_req_before_reset", 32'(imem_req), 1);
        reset_dut();
        checkOutput("hs_req_dropped", 32'(imem_req), 0);

        // Instruction memory that never answers
        cnt       = 0;
        seen_trap = 1'b0;
        for (int c = 0; c < 60 && !seen_trap; c++) begin
            step(NEVER, 0);
            if (trap) seen_trap = 1'b1;
            else if (imem_req) cnt++;
        end
`ifdef UC_MEM_WATCHDOG_EN
        checkOutput("wd_imem_trap", 32'(seen_trap), 1);
        checkOutput("wd_imem_req_cycles", cnt, TIMEOUT_CYC);
        checkOutput("wd_imem_cause", 32'(trap_cause), 2);
        checkOutput("wd_imem_req_dropped", 32'(imem_req), 0);
        reset_dut();
        fetch_decode(make_instr(K_LD), 0, NEVER);
        cnt       = 0;
        seen_trap = 1'b0;
        for (int c = 0; c < 60 && !seen_trap; c++) begin
            step(0, NEVER);
            if (trap) seen_trap = 1'b1;
            else if (dmem_req) cnt++;
        end
        checkOutput("wd_dmem_trap", 32'(seen_trap), 1);
        checkOutput("wd_dmem_req_cycles", cnt, TIMEOUT_CYC);
        checkOutput("wd_dmem_cause", 32'(trap_cause), 3);
        checkOutput("wd_dmem_req_dropped", 32'(dmem_req), 0);
`else
        checkOutput("nowd_no_trap", 32'(seen_trap), 0);
        checkOutput("nowd_req_cycles", cnt, 60);
        checkOutput("nowd_state", 32'(state_dbg), 32'(ST_FETCH));
        checkOutput("nowd_cause", 32'(trap_cause), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
